// File: rtl/xa_bf_pkg.sv
// Shared definitions for the beam forming stage: FSM encodings, DDR beat width,
// and input RAM select constants.
package xa_bf_pkg;

  localparam int unsigned C_DDR_DW = 128;

  localparam logic C_RAM0 = 1'b0;
  localparam logic C_RAM1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/xa_bf_ram_loader.sv
// DDR3-to-input-RAM loader. Each load command fetches P_burst_num bursts of
// P_burst_len beats starting at the frame base address, writes them into
// RAM0 or RAM1 through a single output register, then pulses o_load_end.
module xa_bf_ram_loader
  import xa_bf_pkg::*;
#(
  parameter int unsigned P_dw        = C_DDR_DW,
  parameter int unsigned P_ram_aw    = 10,
  parameter logic [7:0]  P_burst_len = 8'd64,
  parameter logic [7:0]  P_burst_num = 8'd16,
  parameter logic [31:0] P_addr_step = 32'd1024
) (
  input  logic                i_clk156m,
  input  logic                i_rst,
  input  logic                i_load_start,
  input  logic                i_ram_sel,
  input  logic [31:0]         i_base_addr,
  input  logic                i_abort,
  output logic                o_rd_req,
  output logic [31:0]         o_rd_addr,
  output logic [7:0]          o_rd_len,
  input  logic                i_rd_ack,
  input  logic                i_rd_valid,
  input  logic [P_dw-1:0]     i_rd_data,
  output logic                o_ram_we,
  output logic                o_ram_sel,
  output logic [P_ram_aw-1:0] o_ram_addr,
  output logic [P_dw-1:0]     o_ram_wdata,
  output logic                o_load_end,
  output logic                o_busy,
  output logic                o_err
);

  localparam logic [P_ram_aw-1:0] L_one = P_ram_aw'(1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_sel_lat;     // target RAM captured at load start
  logic [31:0]         r_rd_addr;
  logic [7:0]          r_burst_cnt;
  logic [7:0]          r_beat_cnt;
  logic [P_ram_aw-1:0] r_wr_ptr;      // next RAM word to be written
  logic                r_ram_we;
  logic                r_ram_sel;
  logic [P_ram_aw-1:0] r_ram_addr;
  logic [P_dw-1:0]     r_ram_wdata;
  logic                r_err;

  logic                w_beat_ok;
  logic                w_burst_end;
  logic                w_more;
  logic                w_start_ok;
  logic                w_err_set;
  logic [7:0]          w_burst_inc;

  // Next-state decode plus the per-cycle strobes that steer the datapath.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    w_state_nxt = r_state;
    w_beat_ok   = 1'b0;
    w_burst_end = 1'b0;
    w_start_ok  = 1'b0;
    w_burst_inc = r_burst_cnt + 8'd1;
    w_more      = (w_burst_inc < P_burst_num);
    if (i_abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (i_load_start) begin
          w_start_ok  = 1'b1;
          w_state_nxt = ST_REQ;
        end
        ST_REQ: if (i_rd_ack) w_state_nxt = ST_DATA;
        ST_DATA: begin
          // Burst is closed the cycle after its last beat has been taken.
          if (r_beat_cnt == P_burst_len) begin
            w_burst_end = 1'b1;
            w_state_nxt = w_more ? ST_REQ : ST_DONE;
          end else if (i_rd_valid) begin
            w_beat_ok = 1'b1;
          end
        end
        ST_DONE: w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
    // A start while busy and any beat that cannot be stored are protocol errors.
    w_err_set = (i_load_start && (r_state != ST_IDLE)) ||
                (i_rd_valid && ((r_state != ST_DATA) || (r_beat_cnt == P_burst_len)));
  end

  // State register.
  always_ff @(posedge i_clk156m) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Counters, request address, write register and sticky error flag.
  always_ff @(posedge i_clk156m) begin
    if (i_rst) begin
      r_sel_lat   <= C_RAM0;
      r_rd_addr   <= '0;
      r_burst_cnt <= '0;
      r_beat_cnt  <= '0;
      r_wr_ptr    <= '0;
      r_ram_we    <= 1'b0;
      r_ram_sel   <= C_RAM0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_err       <= 1'b0;
    end else begin
      r_ram_we <= w_beat_ok;
      if (w_beat_ok) begin
        r_ram_addr  <= r_wr_ptr;
        r_ram_wdata <= i_rd_data;
        r_ram_sel   <= r_sel_lat;
        r_wr_ptr    <= r_wr_ptr + L_one;
        r_beat_cnt  <= r_beat_cnt + 8'd1;
      end
      if (w_burst_end) begin
        r_beat_cnt  <= '0;
        r_burst_cnt <= w_burst_inc;
        if (w_more) r_rd_addr <= r_rd_addr + P_addr_step;
      end
      if (w_start_ok) begin
        r_sel_lat   <= i_ram_sel;
        r_rd_addr   <= i_base_addr;
        r_burst_cnt <= '0;
        r_beat_cnt  <= '0;
        r_wr_ptr    <= '0;
      end
      if (i_abort) begin
        r_burst_cnt <= '0;
        r_beat_cnt  <= '0;
        r_wr_ptr    <= '0;
      end
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign o_rd_req    = (r_state == ST_REQ);
  assign o_rd_addr   = r_rd_addr;
  assign o_rd_len    = o_rd_req ? P_burst_len : 8'd0;
  assign o_ram_we    = r_ram_we;
  assign o_ram_sel   = r_ram_sel;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_wdata = r_ram_wdata;
  assign o_load_end  = (r_state == ST_DONE);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_err       = r_err;

endmodule

// File: tb/tb_xa_bf_ram_loader.sv
// Directed bench for xa_bf_ram_loader with 4-beat bursts and 2 bursts per load.
module tb_xa_bf_ram_loader;

  logic         clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_load_start = 1'b0;
  logic         i_ram_sel = 1'b0;
  logic [31:0]  i_base_addr = '0;
  logic         i_abort = 1'b0;
  logic         o_rd_req;
  logic [31:0]  o_rd_addr;
  logic [7:0]   o_rd_len;
  logic         i_rd_ack = 1'b0;
  logic         i_rd_valid = 1'b0;
  logic [127:0] i_rd_data = '0;
  logic         o_ram_we;
  logic         o_ram_sel;
  logic [9:0]   o_ram_addr;
  logic [127:0] o_ram_wdata;
  logic         o_load_end;
  logic         o_busy;
  logic         o_err;

  int n_assert = 0;
  int n_fail   = 0;

  xa_bf_ram_loader #(
    .P_dw(128), .P_ram_aw(10), .P_burst_len(8'd4), .P_burst_num(8'd2), .P_addr_step(32'd1024)
  ) dut (
    .i_clk156m(clk), .i_rst(i_rst), .i_load_start(i_load_start), .i_ram_sel(i_ram_sel),
    .i_base_addr(i_base_addr), .i_abort(i_abort), .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr),
    .o_rd_len(o_rd_len), .i_rd_ack(i_rd_ack), .i_rd_valid(i_rd_valid), .i_rd_data(i_rd_data),
    .o_ram_we(o_ram_we), .o_ram_sel(o_ram_sel), .o_ram_addr(o_ram_addr),
    .o_ram_wdata(o_ram_wdata), .o_load_end(o_load_end), .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},    o_rd_req,    0);
    chk({tag, "_rdaddr"}, o_rd_addr,   0);
    chk({tag, "_len"},    o_rd_len,    0);
    chk({tag, "_we"},     o_ram_we,    0);
    chk({tag, "_sel"},    o_ram_sel,   0);
    chk({tag, "_waddr"},  o_ram_addr,  0);
    chk({tag, "_wdata"},  o_ram_wdata, 0);
    chk({tag, "_end"},    o_load_end,  0);
    chk({tag, "_busy"},   o_busy,      0);
    chk({tag, "_err"},    o_err,       0);
  endtask

  // Waits for a request, acknowledges it after ack_dly cycles and returns
  // four beats; each registered write is checked one cycle after its beat.
  task automatic serve_burst(input logic [31:0] exp_rd, input logic [9:0] ram0,
                             input logic sel, input int ack_dly,
                             input logic [31:0] seed, input int poke);
    logic [31:0] w;
    int n;
    n = 0;
    while (o_rd_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", o_rd_req, 1);
    chk("rd_addr", o_rd_addr, exp_rd);
    chk("rd_len", o_rd_len, 4);
    for (int k = 0; k < ack_dly; k++) begin
      tick();
      chk("req_hold", o_rd_req, 1);
      chk("addr_hold", o_rd_addr, exp_rd);
    end
    i_rd_ack = 1'b1;
    tick();
    i_rd_ack = 1'b0;
    chk("req_drop", o_rd_req, 0);
    for (int k = 0; k < 4; k++) begin
      w = seed + 32'(k);
      i_rd_valid = 1'b1;
      i_rd_data  = {4{w}};
      if (k == poke) i_load_start = 1'b1;
      tick();
      i_load_start = 1'b0;
      chk("wr_we", o_ram_we, 1);
      chk("wr_addr", o_ram_addr, 10'(ram0 + 10'(k)));
      chk("wr_data", o_ram_wdata, {4{w}});
      chk("wr_sel", o_ram_sel, sel);
      chk("wr_noend", o_load_end, 0);
    end
    i_rd_valid = 1'b0;
    i_rd_data  = '0;
  endtask

  // One complete load of two bursts, ending in the cycle after o_load_end.
  task automatic run_load(input logic sel, input logic [31:0] base, input logic [31:0] a0,
                          input logic [31:0] a1, input int ack_dly,
                          input logic [31:0] seed, input int poke);
    i_ram_sel    = sel;
    i_base_addr  = base;
    i_load_start = 1'b1;
    tick();
    i_load_start = 1'b0;
    i_ram_sel    = ~sel;
    i_base_addr  = 32'hDEAD_BEEF;
    chk("start_busy", o_busy, 1);
    chk("start_req", o_rd_req, 1);
    serve_burst(a0, 10'd0, sel, ack_dly, seed, poke);
    serve_burst(a1, 10'd4, sel, ack_dly, seed + 32'h100, -1);
    tick();
    chk("end_pulse", o_load_end, 1);
    chk("end_we", o_ram_we, 0);
    chk("end_busy", o_busy, 1);
    tick();
    chk("end_once", o_load_end, 0);
    chk("idle_busy", o_busy, 0);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk_all_zero("rst_hold");
    i_rst = 1'b0;
    tick();
    chk_all_zero("rst_rel");

    // 1: nominal load to RAM0, ack after 3 cycles
    run_load(1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0001_0400, 3, 32'hA000_0000, -1);
    chk("t1_err", o_err, 0);

    // 2: RAM1, back-to-back loads both starting at RAM address 0
    run_load(1'b1, 32'h0000_2000, 32'h0000_2000, 32'h0000_2400, 1, 32'hB000_0000, -1);
    run_load(1'b1, 32'h0000_8000, 32'h0000_8000, 32'h0000_8400, 0, 32'hB100_0000, -1);
    chk("t2_err", o_err, 0);

    // 5: request address wraps modulo 2^32
    run_load(1'b0, 32'hFFFF_FC00, 32'hFFFF_FC00, 32'h0000_0000, 1, 32'hE000_0000, -1);
    chk("t5_err", o_err, 0);

    // 3: start pulsed during ST_DATA is ignored but flagged
    run_load(1'b0, 32'h0000_3000, 32'h0000_3000, 32'h0000_3400, 1, 32'hD000_0000, 1);
    chk("t3_err", o_err, 1);
    repeat (3) tick();
    chk("t3_err_sticky", o_err, 1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("t3_err_clr", o_err, 0);
    tick();

    // 4: abort after 2 of 4 beats
    i_ram_sel    = 1'b1;
    i_base_addr  = 32'h0000_5000;
    i_load_start = 1'b1;
    tick();
    i_load_start = 1'b0;
    chk("t4_req", o_rd_req, 1);
    i_rd_ack = 1'b1;
    tick();
    i_rd_ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_rd_valid = 1'b1;
      i_rd_data  = {4{32'hF000_0000 + 32'(k)}};
      tick();
      chk("t4_we", o_ram_we, 1);
      chk("t4_addr", o_ram_addr, 10'(k));
    end
    i_rd_valid = 1'b0;
    i_abort    = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("t4_busy", o_busy, 0);
    chk("t4_req_drop", o_rd_req, 0);
    chk("t4_no_we", o_ram_we, 0);
    chk("t4_no_end", o_load_end, 0);
    tick();
    chk("t4_no_we2", o_ram_we, 0);
    chk("t4_no_end2", o_load_end, 0);
    // abort wins over a simultaneous start
    i_abort      = 1'b1;
    i_load_start = 1'b1;
    tick();
    i_abort      = 1'b0;
    i_load_start = 1'b0;
    chk("t4_prio_busy", o_busy, 0);
    chk("t4_prio_err", o_err, 0);
    run_load(1'b0, 32'h0000_6000, 32'h0000_6000, 32'h0000_6400, 2, 32'hC000_0000, -1);
    chk("t4_err", o_err, 0);

    // 6a: stray beat while idle
    i_rd_valid = 1'b1;
    i_rd_data  = {4{32'h1234_5678}};
    tick();
    i_rd_valid = 1'b0;
    chk("t6_no_we", o_ram_we, 0);
    chk("t6_err", o_err, 1);

    // 6b: reset mid-burst
    i_ram_sel    = 1'b1;
    i_base_addr  = 32'h0000_7000;
    i_load_start = 1'b1;
    tick();
    i_load_start = 1'b0;
    i_rd_ack = 1'b1;
    tick();
    i_rd_ack   = 1'b0;
    i_rd_valid = 1'b1;
    i_rd_data  = {4{32'h7777_0001}};
    tick();
    i_rd_data  = {4{32'h7777_0002}};
    tick();
    i_rd_valid = 1'b0;
    chk("t6_pre_we", o_ram_we, 1);
    chk("t6_pre_addr", o_ram_addr, 1);
    chk("t6_pre_rd", o_rd_addr, 32'h0000_7000);
    i_rst = 1'b1;
    tick();
    chk_all_zero("t6_rst");
    i_rst = 1'b0;
    tick();
    chk("t6_idle", o_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
